// File: rtl/ring_meas_seq.sv
// Ring-oscillator measurement sequencer: sweeps the enabled rings one at a time.
// Each ring settles, is gated for a fixed window, and its Gray count delta is handed out via valid/ack.
module ring_meas_seq #(
  parameter int          pRINGS  = 5,
  parameter int          pCW     = 16,
  parameter int          pSETTLE = 16,
  parameter int unsigned pWINDOW = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic [pRINGS-1:0] i_mask,
  input  logic [pCW-1:0]    i_gray,
  input  logic              i_ack,
  output logic [pRINGS-1:0] o_ring_en,
  output logic              o_gate,
  output logic              o_busy,
  output logic              o_valid,
  output logic [2:0]        o_ring_id,
  output logic [pCW-1:0]    o_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_CONVERT,
    S_PRESENT
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  localparam logic [31:0] SETTLE_LAST = 32'(pSETTLE - 1);
  localparam logic [31:0] WINDOW_LAST = 32'(pWINDOW - 1);

  state_e            state_q, state_d;
  logic [pRINGS-1:0] mask_q, mask_d;
  logic [2:0]        cur_q, cur_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [pCW-1:0]    a_q, a_d;
  logic [pCW-1:0]    b_q, b_d;
  logic [pCW-1:0]    count_q, count_d;
  logic [2:0]        ring_id_q, ring_id_d;
  pick_t             nxt;

  function automatic logic [pCW-1:0] gray2bin(input logic [pCW-1:0] g);
    logic [pCW-1:0] b;
    b[pCW-1] = g[pCW-1];
    for (int i = pCW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [pRINGS-1:0] m);
    lowest_set = '0;
    for (int i = pRINGS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  // Lowest enabled ring strictly above cur; found=0 means the sweep is complete.
  function automatic pick_t next_above(input logic [pRINGS-1:0] m, input logic [2:0] cur);
    next_above = '0;
    for (int i = pRINGS - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) begin
        next_above.found = 1'b1;
        next_above.idx   = 3'(i);
      end
    end
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    mask_d    = mask_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    count_d   = count_q;
    ring_id_d = ring_id_q;
    nxt       = next_above(mask_q, cur_q);

    case (state_q)
      S_IDLE: begin
        if ((i_start || i_cont) && (|i_mask)) begin
          mask_d  = i_mask;
          cur_d   = lowest_set(i_mask);
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          a_d     = i_gray;
          state_d = S_GATE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // A and B are taken exactly pWINDOW edges apart, so synchronizer delay cancels out.
      S_GATE: begin
        if (cnt_q == WINDOW_LAST) begin
          cnt_d   = '0;
          b_d     = i_gray;
          state_d = S_CONVERT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_CONVERT: begin
        count_d   = gray2bin(b_q) - gray2bin(a_q);
        ring_id_d = cur_q;
        state_d   = S_PRESENT;
      end

      S_PRESENT: begin
        if (i_ack) begin
          cnt_d = '0;
          if (nxt.found) begin
            cur_d   = nxt.idx;
            state_d = S_SETTLE;
          end else if (i_cont) begin
            cur_d   = lowest_set(mask_q);
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      count_q   <= '0;
      ring_id_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q   <= state_d;
      mask_q    <= mask_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      count_q   <= count_d;
      ring_id_q <= ring_id_d;
    end
  end

  // Outputs decode the registered state, so async reset drops them immediately.
  assign o_ring_en = ((state_q == S_SETTLE) || (state_q == S_GATE)) ? (pRINGS'(1) << cur_q) : '0;
  assign o_gate    = (state_q == S_GATE);
  assign o_busy    = (state_q != S_IDLE);
  assign o_valid   = (state_q == S_PRESENT);
  assign o_ring_id = ring_id_q;
  assign o_count   = count_q;

endmodule

// File: tb/tb_ring_meas_seq.sv
// Self-checking bench for ring_meas_seq: a timeline model of each measurement checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ring_meas_seq;

  localparam int S  = 4;
  localparam int W  = 10;
  localparam int HN = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cont, ack;
  logic [4:0]  mask;
  logic [15:0] gray_bin;
  logic [15:0] gray;
  logic [4:0]  ring_en;
  logic        gate, busy, valid;
  logic [2:0]  ring_id;
  logic [15:0] count;

  int vectors     = 0;
  int miscompares = 0;

  assign gray = gray_bin ^ (gray_bin >> 1);

  ring_meas_seq #(
    .pRINGS (5),
    .pCW    (16),
    .pSETTLE(S),
    .pWINDOW(W)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_cont   (cont),
    .i_mask   (mask),
    .i_gray   (gray),
    .i_ack    (ack),
    .o_ring_en(ring_en),
    .o_gate   (gate),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_ring_id(ring_id),
    .o_count  (count)
  );

  always #5 clk = ~clk;

  // Ring counter stand-in: binary value advances by 3 every reference clock.
  always @(negedge clk) gray_bin = gray_bin + 16'd3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // A measurement starts at an edge; k = edges since then. Ring on for k < S+W,
  // gate for S <= k < S+W, result presented from k = S+W+1 until acked.
  int          cyc     = 0;
  bit          m_busy  = 1'b0;
  logic [4:0]  m_mask  = '0;
  int          m_ring  = 0;
  int          m_start = 0;
  logic [15:0] hist [HN];

  function automatic int low_bit(input logic [4:0] m);
    for (int i = 0; i < 5; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int bit_above(input logic [4:0] m, input int cur);
    for (int i = cur + 1; i < 5; i++) if (m[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
    end else begin
      cyc = cyc + 1;
      hist[cyc % HN] = gray_bin;
      if (!m_busy) begin
        if ((start || cont) && (mask != 0)) begin
          m_busy  = 1'b1;
          m_mask  = mask;
          m_ring  = low_bit(mask);
          m_start = cyc;
        end
      end else if ((cyc - 1 - m_start >= S + W + 1) && ack) begin
        if (bit_above(m_mask, m_ring) >= 0) begin
          m_ring  = bit_above(m_mask, m_ring);
          m_start = cyc;
        end else if (cont) begin
          m_ring  = low_bit(m_mask);
          m_start = cyc;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  int         en_cnt   = 0;
  int         gate_cnt = 0;
  int         en_bad   = 0;
  logic [4:0] en_seen  = '0;

  always @(negedge clk) begin
    int          k;
    logic [4:0]  e_en;
    bit          e_valid;
    logic [15:0] e_cnt;
    k       = cyc - m_start;
    e_en    = (m_busy && k < S + W) ? 5'(1 << m_ring) : 5'd0;
    e_valid = m_busy && (k >= S + W + 1);
    check("ring_en", 32'(ring_en), 32'(e_en));
    check("gate", 32'(gate), 32'(m_busy && k >= S && k < S + W));
    check("valid", 32'(valid), 32'(e_valid));
    check("busy", 32'(busy), 32'(m_busy));
    if (e_valid) begin
      e_cnt = hist[(m_start + S + W) % HN] - hist[(m_start + S) % HN];
      check("count", 32'(count), 32'(e_cnt));
      check("ring_id", 32'(ring_id), 32'(m_ring));
    end
    en_seen = en_seen | ring_en;
    if ($countones(ring_en) > 1) en_bad++;
    if (ring_en != 0) en_cnt++;
    if (gate) gate_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("valid_seen", 32'(valid), 32'd1);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask

  initial begin
    int lat, en0, g0, bad0;
    int ids[4];
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; ack = 1'b0; mask = '0; gray_bin = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_en", 32'(ring_en), 32'd0);
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_id", 32'(ring_id), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic measurement on ring 0
    mask = 5'b00001;
    en0 = en_cnt; g0 = gate_cnt;
    pulse_start();
    wait_valid(lat);
    check("basic_latency", 32'(lat), 32'd15);
    check("basic_count", 32'(count), 32'd30);
    check("basic_id", 32'(ring_id), 32'd0);
    ack_pulse();
    check("basic_idle", 32'(busy), 32'd0);
    check("basic_en_cycles", 32'(en_cnt - en0), 32'd14);
    check("basic_gate_cycles", 32'(gate_cnt - g0), 32'd10);

    // Counter wrap across 16'hFFFF
    @(posedge clk); #1 gray_bin = 16'hFFF0;
    pulse_start();
    wait_valid(lat);
    check("wrap_count", 32'(count), 32'd30);
    ack_pulse();

    // Sparse mask, ack held high
    mask = 5'b10100; ack = 1'b1; en_seen = '0; bad0 = en_bad;
    pulse_start();
    wait_valid(lat);
    ids[0] = int'(ring_id);
    @(negedge clk);
    wait_valid(lat);
    ids[1] = int'(ring_id);
    @(negedge clk) ack = 1'b0;
    check("sparse_id0", 32'(ids[0]), 32'd2);
    check("sparse_id1", 32'(ids[1]), 32'd4);
    check("sparse_idle", 32'(busy), 32'd0);
    check("sparse_en_union", 32'(en_seen), 32'b10100);
    check("sparse_en_onehot", 32'(en_bad - bad0), 32'd0);

    // Backpressure: hold the result for 20 cycles
    mask = 5'b00011;
    pulse_start();
    wait_valid(lat);
    check("bp_id", 32'(ring_id), 32'd0);
    repeat (20) begin
      @(negedge clk);
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_count", 32'(count), 32'd30);
      check("bp_id_hold", 32'(ring_id), 32'd0);
      check("bp_en_off", 32'(ring_en), 32'd0);
    end
    ack_pulse();
    check("bp_next_ring", 32'(ring_en), 32'b00010);
    wait_valid(lat);
    check("bp_id1", 32'(ring_id), 32'd1);
    ack_pulse();
    check("bp_idle", 32'(busy), 32'd0);

    // Continuous mode, dropped during ring 1 of the second sweep
    @(negedge clk) begin mask = 5'b00011; cont = 1'b1; end
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      wait_valid(lat);
      ids[n] = int'(ring_id);
      ack_pulse();
      if (n == 2) cont = 1'b0;
    end
    check("cont_seq0", 32'(ids[0]), 32'd0);
    check("cont_seq1", 32'(ids[1]), 32'd1);
    check("cont_seq2", 32'(ids[2]), 32'd0);
    check("cont_seq3", 32'(ids[3]), 32'd1);
    check("cont_idle", 32'(busy), 32'd0);
    mask = 5'b00000; cont = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("zero_mask_busy", 32'(busy), 32'd0);
    end
    cont = 1'b0;

    // Reset mid-GATE
    mask = 5'b00001;
    pulse_start();
    lat = 0;
    while (!gate && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("gate_seen", 32'(gate), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_gate_now", 32'(gate), 32'd0);
    check("rst_en_now", 32'(ring_en), 32'd0);
    check("rst_valid_now", 32'(valid), 32'd0);
    check("rst_busy_now", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_idle", 32'(busy), 32'd0);
    end
    pulse_start();
    wait_valid(lat);
    check("post_rst_latency", 32'(lat), 32'd15);
    check("post_rst_count", 32'(count), 32'd30);

    // Reset while a result is pending discards it
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_present_valid", 32'(valid), 32'd0);
    check("rst_present_count", 32'(count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_present_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
